// File: rtl/cpu_pkg.sv
// Shared constants for the accumulator CPU: sequencer state encoding and
// the opcode map used by both the sequencer and the decoder.
package cpu_pkg;

  // Sequencer states (2-bit, legacy-compatible encoding)
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC1 = 2'd1;
  localparam logic [1:0] S_EXEC2 = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  // Opcode map (4-bit opcode field at the top of the instruction word)
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JMI = 4'h5;
  localparam logic [3:0] OP_JEQ = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h9;
  localparam logic [3:0] OP_XOR = 4'ha;
  localparam logic [3:0] OP_NOT = 4'hb;
  localparam logic [3:0] OP_SHL = 4'hc;
  localparam logic [3:0] OP_ASR = 4'hd;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundle between the sequencer and its surroundings (RAM, accumulator,
// decoder). The step signal exists only when CPU_SEQ_SINGLE_STEP_EN is defined.
//
// Flow control: there is no valid/ready pair here. run is the only throttle;
// a phase takes effect on exactly those cycles where its strobe is high, and
// the decoder must act on a strobe in the same cycle it is asserted.
interface cpu_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 4,
  parameter int CNT_W  = 16
);
  logic                    run;
  logic [DATA_W-1:0]       mem_q;
  logic [DATA_W-1:0]       acc;
  logic                    extra;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic                    step;
`endif
  logic                    fetch;
  logic                    exec1;
  logic                    exec2;
  logic [OPC_W-1:0]        ir;
  logic [DATA_W-OPC_W-1:0] operand;
  logic                    eq;
  logic                    mi;
  logic                    halted;
  logic [CNT_W-1:0]        cycle_cnt;
  logic [1:0]              state;   // debug view of the sequencer FSM

  // Environment side: drives the sequencer inputs, observes its outputs
  modport master (
`ifdef CPU_SEQ_SINGLE_STEP_EN
    output step,
`endif
    output run, mem_q, acc, extra,
    input  fetch, exec1, exec2, ir, operand, eq, mi, halted, cycle_cnt, state
  );

  // Sequencer side
  modport slave (
`ifdef CPU_SEQ_SINGLE_STEP_EN
    input  step,
`endif
    input  run, mem_q, acc, extra,
    output fetch, exec1, exec2, ir, operand, eq, mi, halted, cycle_cnt, state
  );
endinterface

// File: rtl/cpu_flag_gen.sv
// Accumulator flags for the decoder: EQ when the accumulator is zero,
// MI when its sign bit is set. Purely combinational.
module cpu_flag_gen #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] acc,
  output logic              eq,
  output logic              mi
);

  assign eq = (acc == '0);
  assign mi = acc[DATA_W-1];

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction-cycle timing generator for the accumulator CPU. Latches the
// instruction word during FETCH, drives FETCH/EXEC1/EXEC2 strobes, halts on
// STP and counts executed cycles (saturating).
// Optional feature macro: CPU_SEQ_SINGLE_STEP_EN (one instruction per STEP
// rising edge while run is low).
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int               DATA_W     = 16,
  parameter int               OPC_W      = 4,
  parameter int               CNT_W      = 16,
  parameter logic [OPC_W-1:0] STP_OPCODE = OP_STP
) (
  input  logic           clk,
  input  logic           rst,
  cpu_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic [OPC_W-1:0]        ir;
  logic [DATA_W-OPC_W-1:0] operand;
  logic                    halted;
  logic [CNT_W-1:0]        cycle_cnt;
  logic                    advance;
  logic                    is_stp;
  logic                    instr_end;

  assign is_stp = (ir == STP_OPCODE);

`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic step_d;
  logic step_active;

  // Arm one whole instruction on a STEP rising edge while frozen; drop it
  // when that instruction completes (back to FETCH or into HALT)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_d      <= 1'b0;
      step_active <= 1'b0;
    end else begin
      step_d <= bus.step;
      if (step_active && instr_end) begin
        step_active <= 1'b0;
      end else if (!bus.run && bus.step && !step_d && !step_active && !halted) begin
        step_active <= 1'b1;
      end
    end
  end

  assign advance = (bus.run | step_active) & ~halted;
`else
  assign advance = bus.run & ~halted;
`endif

  // Next-state selection; instr_end marks the edge that finishes an instruction
  always_comb begin
    state_nxt = state;
    instr_end = 1'b0;
    if (advance) begin
      case (state)
        S_FETCH: state_nxt = S_EXEC1;
        S_EXEC1: begin
          if (is_stp) begin
            state_nxt = S_HALT;
            instr_end = 1'b1;
          end else if (bus.extra) begin
            state_nxt = S_EXEC2;
          end else begin
            state_nxt = S_FETCH;
            instr_end = 1'b1;
          end
        end
        S_EXEC2: begin
          state_nxt = S_FETCH;
          instr_end = 1'b1;
        end
        default: state_nxt = S_HALT;
      endcase
    end
  end

  // State, instruction latch, sticky halt flag and saturating cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      ir        <= '0;
      operand   <= '0;
      halted    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (advance && state == S_FETCH) begin
        {ir, operand} <= bus.mem_q;
      end
      if (advance && state == S_EXEC1 && is_stp) begin
        halted <= 1'b1;
      end
      if (advance && cycle_cnt != CNT_MAX) begin
        cycle_cnt <= cycle_cnt + CNT_ONE;
      end
    end
  end

  // Strobes are gated by advance so frozen cycles have no decoder side effects
  assign bus.fetch     = advance && (state == S_FETCH);
  assign bus.exec1     = advance && (state == S_EXEC1);
  assign bus.exec2     = advance && (state == S_EXEC2);
  assign bus.ir        = ir;
  assign bus.operand   = operand;
  assign bus.halted    = halted;
  assign bus.cycle_cnt = cycle_cnt;
  assign bus.state     = state;

  cpu_flag_gen #(.DATA_W(DATA_W)) u_flags (
    .acc (bus.acc),
    .eq  (bus.eq),
    .mi  (bus.mi)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus randomized traffic, each
// cycle compared against an instruction-level reference model.
module tb_cpu_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        run   = 1'b0;
  logic [15:0] mem_q = '0;
  logic        extra = 1'b0;
  logic [15:0] acc   = '0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic        step  = 1'b0;
`endif

  cpu_sequencer_if #(.DATA_W(16), .OPC_W(4), .CNT_W(16)) u_if ();
  assign u_if.run   = run;
  assign u_if.mem_q = mem_q;
  assign u_if.extra = extra;
  assign u_if.acc   = acc;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  assign u_if.step  = step;
`endif

  cpu_sequencer #(.DATA_W(16), .OPC_W(4), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  // Narrow-counter instance: always running a non-halting instruction
  cpu_sequencer_if #(.DATA_W(16), .OPC_W(4), .CNT_W(3)) u_if3 ();
  assign u_if3.run   = 1'b1;
  assign u_if3.mem_q = 16'h2005;
  assign u_if3.extra = 1'b0;
  assign u_if3.acc   = 16'h0001;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  assign u_if3.step  = 1'b0;
`endif

  cpu_sequencer #(.DATA_W(16), .OPC_W(4), .CNT_W(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (u_if3.slave)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Position within the current instruction: 0 fetch, 1 exec1, 2 exec2.
  int          m_pos;
  bit          m_halted;
  int          m_ir;
  int          m_opd;
  int          m_cnt;
  bit          m_step;        // one instruction granted by a STEP pulse
  bit          m_step_prev;
  logic [2:0]  obs_strb;
  int          obs_cnt;

  task automatic model_reset();
    m_pos = 0; m_halted = 0; m_ir = 0; m_opd = 0; m_cnt = 0;
    m_step = 0; m_step_prev = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Both tasks start and end at a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_fetch",   u_if.fetch, run);
    chk("rst_exec",    {u_if.exec1, u_if.exec2}, 0);
    chk("rst_ir",      u_if.ir, 0);
    chk("rst_operand", u_if.operand, 0);
    chk("rst_cnt",     u_if.cycle_cnt, 0);
    chk("rst_halted",  u_if.halted, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_cycle(input logic r, input logic [15:0] mq, input logic ex,
                          input logic [15:0] ac, input logic st);
    bit adv;
    int exp_strb;
    bit done;
    run = r; mem_q = mq; extra = ex; acc = ac;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    step = st;
`endif
    #1;
    adv = (r || m_step) && !m_halted;
    exp_strb = !adv ? 0 : (m_pos == 0) ? 4 : (m_pos == 1) ? 2 : 1;
    obs_strb = {u_if.fetch, u_if.exec1, u_if.exec2};
    obs_cnt  = int'(u_if.cycle_cnt);
    chk("strobes", obs_strb, exp_strb);
    chk("ir",      u_if.ir, m_ir);
    chk("operand", u_if.operand, m_opd);
    chk("cnt",     u_if.cycle_cnt, m_cnt);
    chk("halted",  u_if.halted, m_halted);
    chk("eq",      u_if.eq, (ac == 0));
    chk("mi",      u_if.mi, (ac >= 16'h8000));
    // advance the model across the coming rising edge
    done = 0;
    if (adv) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_pos == 0) begin
        m_ir  = mq / 4096;
        m_opd = mq % 4096;
        m_pos = 1;
      end else if (m_pos == 1) begin
        if (m_ir == 7) begin
          m_halted = 1;
          done = 1;
        end else if (ex) begin
          m_pos = 2;
        end else begin
          m_pos = 0;
          done = 1;
        end
      end else begin
        m_pos = 0;
        done = 1;
      end
    end
`ifdef CPU_SEQ_SINGLE_STEP_EN
    if (m_step && done) m_step = 0;
    else if (!r && st && !m_step_prev && !m_step && !m_halted) m_step = 1;
`endif
    m_step_prev = st;
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [3:0]  op;
    logic [15:0] mq;
    logic [15:0] ac;
    int          base_cnt;
    int          strobed;
    model_reset();
    @(negedge clk);
    run = 1'b1;
    do_reset();

    // ADD with EXTRA: fetch, exec1, exec2, fetch
    do_cycle(1, 16'h2005, 1, 16'h0000, 0);
    chk("add_c1", obs_strb, 3'b100);
    do_cycle(1, 16'h2005, 1, 16'h1234, 0);
    chk("add_c2", obs_strb, 3'b010);
    chk("add_ir", u_if.ir, 2);
    chk("add_opd", u_if.operand, 12'h005);
    do_cycle(1, 16'h2005, 1, 16'h8001, 0);
    chk("add_c3", obs_strb, 3'b001);
    do_cycle(1, 16'h4010, 0, 16'hffff, 0);
    chk("add_c4", obs_strb, 3'b100);
    chk("add_cnt3", obs_cnt, 3);

    // JMP without EXTRA: fetch, exec1, fetch
    do_cycle(1, 16'h4010, 0, 16'h0000, 0);
    chk("jmp_c2", obs_strb, 3'b010);
    chk("jmp_ir", u_if.ir, 4);
    chk("jmp_opd", u_if.operand, 12'h010);
    do_cycle(1, 16'h2005, 0, 16'h0000, 0);
    chk("jmp_c3", obs_strb, 3'b100);

    // RUN low for 5 cycles in exec1: frozen, then resumes in exec1
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, 16'h2005, 1, 16'h0042, 0);
      chk("frz_strb", obs_strb, 3'b000);
      chk("frz_cnt", obs_cnt, 6);
    end
    do_cycle(1, 16'h2005, 1, 16'h0042, 0);
    chk("resume_exec1", obs_strb, 3'b010);
    do_cycle(1, 16'h2005, 1, 16'h0042, 0);
    chk("resume_exec2", obs_strb, 3'b001);

    // Reset pulse mid-EXEC2
    do_cycle(1, 16'h3abc, 1, 16'h0000, 0);
    do_cycle(1, 16'h3abc, 1, 16'h0000, 0);
    do_reset();
    do_cycle(1, 16'h1001, 0, 16'h0000, 0);
    chk("post_rst_fetch", obs_strb, 3'b100);

    // Randomized traffic (no STP so the machine keeps running)
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'h7) op = 4'h2;
      mq = {op, 12'($urandom)};
      case ($urandom_range(0, 3))
        0:       ac = 16'h0000;
        1:       ac = 16'($urandom_range(16'h8000, 16'hffff));
        default: ac = 16'($urandom);
      endcase
      do_cycle($urandom_range(0, 3) != 0, mq, 1'($urandom_range(0, 1)), ac,
               $urandom_range(0, 5) == 0);
    end

    // STP halts; strobes stay low and counter frozen despite RUN toggling
    do_reset();
    do_cycle(1, 16'h7000, 1, 16'h0000, 0);
    do_cycle(1, 16'h7000, 1, 16'h0000, 0);
    chk("stp_exec1", obs_strb, 3'b010);
    chk("stp_halted", u_if.halted, 1);
    base_cnt = int'(u_if.cycle_cnt);
    chk("stp_cnt", base_cnt, 2);
    for (int i = 0; i < 20; i++) begin
      do_cycle(1'(i % 2), 16'h2005, 1, 16'h0000, 1'(i % 3 == 0));
      chk("halt_strb", obs_strb, 3'b000);
      chk("halt_cnt", obs_cnt, 2);
    end
    chk("halt_sticky", u_if.halted, 1);

    // Narrow counter saturates at 7
    do_reset();
    for (int i = 0; i < 5; i++) do_cycle(1, 16'h2005, 0, 16'h0000, 0);
    chk("cnt3_5", u_if3.cycle_cnt, 5);
    for (int i = 0; i < 5; i++) do_cycle(1, 16'h2005, 0, 16'h0000, 0);
    chk("cnt3_sat", u_if3.cycle_cnt, 7);

`ifdef CPU_SEQ_SINGLE_STEP_EN
    // One STEP pulse with RUN low executes exactly one ADD (3 strobed cycles)
    do_reset();
    do_cycle(0, 16'h2005, 1, 16'h0000, 0);
    do_cycle(0, 16'h2005, 1, 16'h0000, 0);
    do_cycle(0, 16'h2005, 1, 16'h0000, 1);
    chk("step_arm", obs_strb, 3'b000);
    strobed = 0;
    for (int i = 0; i < 8; i++) begin
      do_cycle(0, 16'h2005, 1, 16'h0000, 0);
      if (obs_strb != 3'b000) strobed++;
    end
    chk("step_count", strobed, 3);
    chk("step_cnt", u_if.cycle_cnt, 3);
    do_cycle(0, 16'h2005, 1, 16'h0000, 0);
    chk("step_frozen", obs_strb, 3'b000);
`else
    strobed = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
